// File: rtl/dac_feed_ctrl_if.sv
// dac_feed_ctrl_if: sample, strobe, config and status signals between processor side and DAC feed controller
interface dac_feed_ctrl_if;
    logic signed [23:0] din;
    logic               din_en;
    logic               rclk_tick;
    logic               cfg_req;
    logic               cfg_isi;
    logic               cfg_mis;
    logic               mute_req;
    logic signed [23:0] dout;
    logic               isi_sel;
    logic               mis_sel;
    logic               busy;
    logic               underrun;
    modport master (
        output din, din_en, rclk_tick, cfg_req, cfg_isi, cfg_mis, mute_req,
        input  dout, isi_sel, mis_sel, busy, underrun
    );
    modport slave (
        input  din, din_en, rclk_tick, cfg_req, cfg_isi, cfg_mis, mute_req,
        output dout, isi_sel, mis_sel, busy, underrun
    );
endinterface

// File: rtl/dac_feed_ctrl.sv
// dac_feed_ctrl: DAC sample feed with gain-ramped soft mute and click-free mode-select switching
module dac_feed_ctrl #(
    parameter logic [8:0] GAIN_STEP = 9'd1,
    parameter int         HOLD_CNT  = 16,
    parameter logic       DEF_ISI   = 1'b0,
    parameter logic       DEF_MIS   = 1'b0
) (
    input logic            m_clk,
    input logic            rst_n,
    dac_feed_ctrl_if.slave bus
);
    typedef enum logic [2:0] {RUN, RAMP_DN, HOLD, SWITCH, MUTED, RAMP_UP} state_t;
    state_t             state;
    logic [8:0]         gain, gain_up, gain_dn, gain_tk;
    logic [9:0]         up_sum;
    logic signed [23:0] held, last_smp, smp;
    logic signed [33:0] prod;
    logic [7:0]         hold_cnt;
    logic               valid, diff, take_cfg, pend_isi, pend_mis;
    // gain_tk is the gain after this cycle's tick; transitions are decided on it
    always_comb begin
        up_sum   = {1'b0, gain} + {1'b0, GAIN_STEP};
        gain_up  = up_sum >= 10'd256 ? 9'd256 : up_sum[8:0];
        gain_dn  = gain <= GAIN_STEP ? 9'd0 : gain - GAIN_STEP;
        gain_tk  = !bus.rclk_tick ? gain :
                   state == RUN     ? 9'd256 :
                   state == RAMP_DN ? gain_dn :
                   state == RAMP_UP ? gain_up : 9'd0;
        smp      = bus.din_en ? bus.din : valid ? held : last_smp;
        prod     = $signed({{10{smp[23]}}, smp}) * $signed({25'd0, gain});
        diff     = bus.cfg_req && {bus.cfg_isi, bus.cfg_mis} != {bus.isi_sel, bus.mis_sel};
        take_cfg = state inside {RAMP_DN, HOLD, SWITCH} ? bus.cfg_req : diff;
    end
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RAMP_UP;
            gain         <= '0;
            held         <= '0;
            last_smp     <= '0;
            valid        <= 1'b0;
            hold_cnt     <= '0;
            pend_isi     <= DEF_ISI;
            pend_mis     <= DEF_MIS;
            bus.dout     <= '0;
            bus.isi_sel  <= DEF_ISI;
            bus.mis_sel  <= DEF_MIS;
            bus.busy     <= 1'b1;
            bus.underrun <= 1'b0;
        end else begin
            bus.underrun <= bus.rclk_tick && !bus.din_en && !valid;
            if (bus.rclk_tick) begin
                valid    <= 1'b0;
                last_smp <= smp;
                bus.dout <= 24'(prod >>> 8);
                gain     <= gain_tk;
            end else if (bus.din_en) begin
                held  <= bus.din;
                valid <= 1'b1;
            end
            if (take_cfg)
                {pend_isi, pend_mis} <= {bus.cfg_isi, bus.cfg_mis};
            case (state)
                RUN: if (diff || bus.mute_req) begin
                    state    <= RAMP_DN;
                    bus.busy <= 1'b1;
                end
                RAMP_DN: if (gain_tk == 9'd0) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: if (bus.rclk_tick) begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == 8'(HOLD_CNT - 1))
                        state <= SWITCH;
                end
                // gain is zero here, so the selects may move
                SWITCH: begin
                    {bus.isi_sel, bus.mis_sel} <= bus.cfg_req ? {bus.cfg_isi, bus.cfg_mis} : {pend_isi, pend_mis};
                    state <= bus.mute_req ? MUTED : RAMP_UP;
                end
                MUTED: if (diff) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end else if (!bus.mute_req)
                    state <= RAMP_UP;
                RAMP_UP: if (diff || bus.mute_req)
                    state <= RAMP_DN;
                else if (gain_tk == 9'd256) begin
                    state    <= RUN;
                    bus.busy <= 1'b0;
                end
                default: state <= RAMP_UP;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_feed_ctrl.sv
// tb_dac_feed_ctrl: directed vector table plus ramp/switch/mute/reset sequences for dac_feed_ctrl
module tb_dac_feed_ctrl;
    logic m_clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    dac_feed_ctrl_if bus();
    dac_feed_ctrl dut (.m_clk(m_clk), .rst_n(rst_n), .bus(bus));
    always #5 m_clk = ~m_clk;
    typedef struct {
        logic [23:0] din;
        logic        en;
        logic        tk;
        logic [23:0] dout;
        logic        und;
    } vec_t;
    vec_t vt[12];
    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic cyc(input logic [23:0] d, input logic en, input logic tk, input logic cr, input logic [1:0] c);
        bus.din = d;
        bus.din_en = en;
        bus.rclk_tick = tk;
        bus.cfg_req = cr;
        {bus.cfg_isi, bus.cfg_mis} = c;
        @(posedge m_clk);
        #1;
        bus.din_en = 1'b0;
        bus.rclk_tick = 1'b0;
        bus.cfg_req = 1'b0;
    endtask
    task automatic idle();
        cyc(24'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask
    task automatic tick(input logic [23:0] d);
        cyc(d, 1'b1, 1'b1, 1'b0, 2'b00);
    endtask
    task automatic ramp_up_chk(input string nm, input int n, input logic [1:0] s);
        for (int k = 0; k < n; k++) begin
            tick(k == 128 ? 24'h800000 : 24'h100000);
            chk(nm, bus.dout, k == 128 ? 24'hC00000 : 24'(k * 4096));
            chk({nm, "_sel"}, 24'({bus.isi_sel, bus.mis_sel}), 24'(s));
        end
    endtask
    task automatic ramp_dn_chk(input string nm, input int n, input logic [1:0] s);
        for (int k = 0; k < n; k++) begin
            tick((n - k) == 128 ? 24'hFFFFFF : 24'h100000);
            chk(nm, bus.dout, (n - k) == 128 ? 24'hFFFFFF : 24'((n - k) * 4096));
            chk({nm, "_sel"}, 24'({bus.isi_sel, bus.mis_sel}), 24'(s));
        end
    endtask
    task automatic hold_chk(input string nm, input logic [1:0] s);
        for (int k = 0; k < 16; k++) begin
            tick(24'h100000);
            chk(nm, bus.dout, 24'd0);
            chk({nm, "_sel"}, 24'({bus.isi_sel, bus.mis_sel}), 24'(s));
        end
    endtask
    initial begin
        bus.din = '0;
        bus.din_en = 1'b0;
        bus.rclk_tick = 1'b0;
        bus.cfg_req = 1'b0;
        bus.cfg_isi = 1'b0;
        bus.cfg_mis = 1'b0;
        bus.mute_req = 1'b0;
        vt[0]  = '{24'h800000, 1'b1, 1'b1, 24'h800000, 1'b0};
        vt[1]  = '{24'h123456, 1'b1, 1'b0, 24'h800000, 1'b0};
        vt[2]  = '{24'h000000, 1'b0, 1'b1, 24'h123456, 1'b0};
        vt[3]  = '{24'h000000, 1'b0, 1'b1, 24'h123456, 1'b1};
        vt[4]  = '{24'h000000, 1'b0, 1'b0, 24'h123456, 1'b0};
        vt[5]  = '{24'h7FFFFF, 1'b1, 1'b1, 24'h7FFFFF, 1'b0};
        vt[6]  = '{24'hFFFFFF, 1'b1, 1'b1, 24'hFFFFFF, 1'b0};
        vt[7]  = '{24'h000001, 1'b1, 1'b0, 24'hFFFFFF, 1'b0};
        vt[8]  = '{24'h000002, 1'b1, 1'b0, 24'hFFFFFF, 1'b0};
        vt[9]  = '{24'h000000, 1'b0, 1'b1, 24'h000002, 1'b0};
        vt[10] = '{24'h000003, 1'b1, 1'b1, 24'h000003, 1'b0};
        vt[11] = '{24'h000000, 1'b0, 1'b1, 24'h000003, 1'b1};
        repeat (3) @(posedge m_clk);
        #1;
        chk("rst_dout", bus.dout, 24'd0);
        chk("rst_busy", 24'(bus.busy), 24'd1);
        chk("rst_sel", 24'({bus.isi_sel, bus.mis_sel}), 24'd0);
        chk("rst_und", 24'(bus.underrun), 24'd0);
        rst_n = 1'b1;
        idle();
        ramp_up_chk("boot_ramp", 256, 2'b00);
        idle();
        chk("boot_busy", 24'(bus.busy), 24'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].din, vt[i].en, vt[i].tk, 1'b0, 2'b00);
            chk($sformatf("vec%0d_dout", i), bus.dout, vt[i].dout);
            chk($sformatf("vec%0d_und", i), 24'(bus.underrun), 24'(vt[i].und));
        end
        cyc(24'd0, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("cfg_busy", 24'(bus.busy), 24'd1);
        ramp_dn_chk("cfg_dn", 256, 2'b00);
        hold_chk("cfg_hold", 2'b00);
        idle();
        chk("cfg_switch", 24'({bus.isi_sel, bus.mis_sel}), 24'b10);
        ramp_up_chk("cfg_up", 256, 2'b10);
        idle();
        chk("cfg_run_busy", 24'(bus.busy), 24'd0);
        cyc(24'd0, 1'b0, 1'b0, 1'b1, 2'b10);
        idle();
        chk("same_cfg_busy", 24'(bus.busy), 24'd0);
        cyc(24'd0, 1'b0, 1'b0, 1'b1, 2'b11);
        ramp_dn_chk("m_dn", 256, 2'b10);
        hold_chk("m_hold", 2'b10);
        idle();
        ramp_up_chk("m_up", 100, 2'b11);
        bus.mute_req = 1'b1;
        idle();
        chk("m_busy", 24'(bus.busy), 24'd1);
        ramp_dn_chk("m_dn100", 100, 2'b11);
        hold_chk("m_hold2", 2'b11);
        idle();
        for (int k = 0; k < 3; k++) begin
            tick(24'h100000);
            chk("muted_dout", bus.dout, 24'd0);
            chk("muted_busy", 24'(bus.busy), 24'd1);
        end
        bus.mute_req = 1'b0;
        idle();
        ramp_up_chk("unmute_up", 256, 2'b11);
        idle();
        chk("unmute_busy", 24'(bus.busy), 24'd0);
        cyc(24'd0, 1'b0, 1'b0, 1'b1, 2'b00);
        ramp_dn_chk("r_dn", 256, 2'b11);
        for (int k = 0; k < 5; k++)
            tick(24'h100000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", bus.dout, 24'd0);
        chk("arst_busy", 24'(bus.busy), 24'd1);
        chk("arst_sel", 24'({bus.isi_sel, bus.mis_sel}), 24'd0);
        chk("arst_und", 24'(bus.underrun), 24'd0);
        #1;
        rst_n = 1'b1;
        @(posedge m_clk);
        #1;
        tick(24'h100000);
        chk("post_rst_t0", bus.dout, 24'd0);
        tick(24'h100000);
        chk("post_rst_t1", bus.dout, 24'h001000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
